// File: rtl/mips_hazard_ctrl.sv
// Pipeline hazard controller: EX operand forwarding, load-use bubbles, branch flushes
// and a multi-cycle multiply stall sequencer with a saturating stall-cycle counter.
module mips_hazard_ctrl #(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic [4:0]       EX_Rs,
    input  logic [4:0]       EX_Rt,
    input  logic [4:0]       EX_Rd,
    input  logic             EX_MemRead,
    input  logic             EX_MulOp,
    input  logic [4:0]       MEM_Rd,
    input  logic [4:0]       WB_Rd,
    input  logic             MEM_RegWrite,
    input  logic             WB_RegWrite,
    input  logic             BranchTaken,
    output logic [1:0]       ForwardA,
    output logic [1:0]       ForwardB,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IDEXWrite,
    output logic             IFIDFlush,
    output logic             IDEXFlush,
    output logic             EXMEMFlush,
    output logic             MulBusy,
    output logic [CNT_W-1:0] StallCycles
);

    typedef enum logic [0:0] {StRun, StMulWait} state_e;

    state_e           state_q, state_d;
    logic [3:0]       mul_cnt_q, mul_cnt_d;
    logic [CNT_W-1:0] stall_q;
    logic             load_use;

    // Forwarding is purely input-driven so it stays valid through reset and stalls.
    always_comb begin
        ForwardA = 2'b00;
        ForwardB = 2'b00;
        if (MEM_RegWrite && (MEM_Rd != 5'd0) && (MEM_Rd == EX_Rs)) begin
            ForwardA = 2'b10;
        end else if (WB_RegWrite && (WB_Rd != 5'd0) && (WB_Rd == EX_Rs)) begin
            ForwardA = 2'b01;
        end
        if (MEM_RegWrite && (MEM_Rd != 5'd0) && (MEM_Rd == EX_Rt)) begin
            ForwardB = 2'b10;
        end else if (WB_RegWrite && (WB_Rd != 5'd0) && (WB_Rd == EX_Rt)) begin
            ForwardB = 2'b01;
        end
    end

    assign load_use = EX_MemRead && (EX_Rd != 5'd0) && ((EX_Rd == ID_Rs) || (EX_Rd == ID_Rt));

    always_comb begin
        state_d    = state_q;
        mul_cnt_d  = mul_cnt_q;
        PCWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        IDEXWrite  = 1'b1;
        IFIDFlush  = 1'b0;
        IDEXFlush  = 1'b0;
        EXMEMFlush = 1'b0;
        MulBusy    = 1'b0;
        // Held in reset, the controls show RUN defaults regardless of inputs.
        if (!Reset) begin
            unique case (state_q)
                StRun: begin
                    if (BranchTaken) begin
                        IFIDFlush = 1'b1;
                        IDEXFlush = 1'b1;
                    end else if (EX_MulOp) begin
                        state_d   = StMulWait;
                        mul_cnt_d = 4'(MUL_LAT - 1);
                    end else if (load_use) begin
                        PCWrite   = 1'b0;
                        IFIDWrite = 1'b0;
                        IDEXFlush = 1'b1;
                    end
                end
                StMulWait: begin
                    PCWrite    = 1'b0;
                    IFIDWrite  = 1'b0;
                    IDEXWrite  = 1'b0;
                    EXMEMFlush = 1'b1;
                    MulBusy    = 1'b1;
                    mul_cnt_d  = mul_cnt_q - 4'd1;
                    // <= 1 also recovers from an unreachable zero count.
                    if (mul_cnt_q <= 4'd1) begin
                        state_d = StRun;
                    end
                end
                default: state_d = StRun;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= StRun;
            mul_cnt_q <= 4'd0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            mul_cnt_q <= mul_cnt_d;
            if (!PCWrite && (stall_q != {CNT_W{1'b1}})) begin
                stall_q <= stall_q + CNT_W'(1);
            end
        end
    end

    assign StallCycles = stall_q;

endmodule
